// File: rtl/tetris_input_ctrl.sv
// Joystick/button front end for tetris_grid: zone FSM with hysteresis, button
// debounce, auto-repeat, and sticky requests that stay set until the grid acks.
module tetris_input_ctrl #(
  parameter int ADC_W           = 12,
  parameter int LEFT_THRESH     = 1000,
  parameter int RIGHT_THRESH    = 3000,
  parameter int HYST            = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 15_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ADC_W-1:0] adc_value,
  input  logic             adc_valid,
  input  logic             btn_rotate_n,
  input  logic             btn_down_n,
  input  logic             ack,
  output logic             move_left,
  output logic             move_right,
  output logic             move_down,
  output logic             rotate
);

  localparam int MAX_RPT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int MAX_CNT = (MAX_RPT > DEBOUNCE_CYCLES) ? MAX_RPT : DEBOUNCE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam int TH_W    = ADC_W + 1;
  localparam int TH_MAX  = (1 << TH_W) - 1;

  // Hysteresis bounds are clamped so they never wrap in TH_W bits.
  localparam logic [TH_W-1:0] L_ENTER = TH_W'(LEFT_THRESH);
  localparam logic [TH_W-1:0] L_EXIT  = TH_W'(((LEFT_THRESH + HYST) > TH_MAX) ? TH_MAX : (LEFT_THRESH + HYST));
  localparam logic [TH_W-1:0] R_ENTER = TH_W'(RIGHT_THRESH);
  localparam logic [TH_W-1:0] R_EXIT  = TH_W'((RIGHT_THRESH > HYST) ? (RIGHT_THRESH - HYST) : 0);

  localparam logic [CNT_W-1:0] RPT_DELAY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RATE  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ZONE_CENTER = 2'd0,
    ZONE_LEFT   = 2'd1,
    ZONE_RIGHT  = 2'd2
  } zone_t;

  zone_t            r_zone;
  zone_t            w_zone_next;
  logic [TH_W-1:0]  w_adc;
  logic [CNT_W-1:0] r_joy_cnt;
  logic             r_left_evt;
  logic             r_right_evt;

  logic [1:0]       w_btn_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_db_level;
  logic [1:0]       w_db_flip;
  logic [CNT_W-1:0] r_db_cnt [2];
  logic [CNT_W-1:0] r_down_cnt;
  logic             r_rot_evt;
  logic             r_down_evt;

  logic             r_move_left;
  logic             r_move_right;
  logic             r_move_down;
  logic             r_rotate;

  assign w_adc     = {1'b0, adc_value};
  assign w_btn_raw = {btn_down_n, btn_rotate_n};

  always_comb begin
    w_zone_next = r_zone;
    if (adc_valid) begin
      case (r_zone)
        ZONE_CENTER: begin
          if (w_adc < L_ENTER)      w_zone_next = ZONE_LEFT;
          else if (w_adc > R_ENTER) w_zone_next = ZONE_RIGHT;
          else                      w_zone_next = ZONE_CENTER;
        end
        ZONE_LEFT: begin
          if (w_adc > R_ENTER)      w_zone_next = ZONE_RIGHT;
          else if (w_adc >= L_EXIT) w_zone_next = ZONE_CENTER;
          else                      w_zone_next = ZONE_LEFT;
        end
        ZONE_RIGHT: begin
          if (w_adc < L_ENTER)      w_zone_next = ZONE_LEFT;
          else if (w_adc <= R_EXIT) w_zone_next = ZONE_CENTER;
          else                      w_zone_next = ZONE_RIGHT;
        end
        default: w_zone_next = ZONE_CENTER;
      endcase
    end else begin
      w_zone_next = r_zone;
    end
  end

  // Zone register plus joystick auto-repeat; entering a side zone fires at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_zone      <= ZONE_CENTER;
      r_joy_cnt   <= '0;
      r_left_evt  <= 1'b0;
      r_right_evt <= 1'b0;
    end else begin
      r_zone      <= w_zone_next;
      r_left_evt  <= 1'b0;
      r_right_evt <= 1'b0;
      if (w_zone_next != r_zone) begin
        if (w_zone_next == ZONE_CENTER) begin
          r_joy_cnt <= '0;
        end else begin
          r_joy_cnt   <= RPT_DELAY;
          r_left_evt  <= (w_zone_next == ZONE_LEFT);
          r_right_evt <= (w_zone_next == ZONE_RIGHT);
        end
      end else if (r_zone != ZONE_CENTER) begin
        if (r_joy_cnt == CNT_ONE) begin
          r_joy_cnt   <= RPT_RATE;
          r_left_evt  <= (r_zone == ZONE_LEFT);
          r_right_evt <= (r_zone == ZONE_RIGHT);
        end else begin
          r_joy_cnt <= r_joy_cnt - CNT_ONE;
        end
      end else begin
        r_joy_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_db_flip = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_db_flip[i] = (r_sync2[i] != r_db_level[i]) && (r_db_cnt[i] == DB_LAST);
    end
  end

  // Button synchronizers and debounce; index 0 is rotate, index 1 is down.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1    <= 2'b11;
      r_sync2    <= 2'b11;
      r_db_level <= 2'b11;
      r_rot_evt  <= 1'b0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= w_btn_raw;
      r_sync2   <= r_sync1;
      r_rot_evt <= w_db_flip[0] & ~r_sync2[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_db_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_db_flip[i]) begin
          r_db_cnt[i]   <= '0;
          r_db_level[i] <= r_sync2[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Soft-drop auto-repeat, timed from the debounced press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_down_cnt <= '0;
      r_down_evt <= 1'b0;
    end else begin
      r_down_evt <= 1'b0;
      if (w_db_flip[1]) begin
        if (!r_sync2[1]) begin
          r_down_cnt <= RPT_DELAY;
          r_down_evt <= 1'b1;
        end else begin
          r_down_cnt <= '0;
        end
      end else if (!r_db_level[1]) begin
        if (r_down_cnt == CNT_ONE) begin
          r_down_cnt <= RPT_RATE;
          r_down_evt <= 1'b1;
        end else begin
          r_down_cnt <= r_down_cnt - CNT_ONE;
        end
      end else begin
        r_down_cnt <= '0;
      end
    end
  end

  // Sticky request latches: an event beats ack; left and right exclude each other.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_move_left  <= 1'b0;
      r_move_right <= 1'b0;
      r_move_down  <= 1'b0;
      r_rotate     <= 1'b0;
    end else begin
      if (r_left_evt) begin
        r_move_left  <= 1'b1;
        r_move_right <= 1'b0;
      end else if (r_right_evt) begin
        r_move_right <= 1'b1;
        r_move_left  <= 1'b0;
      end else if (ack) begin
        r_move_left  <= 1'b0;
        r_move_right <= 1'b0;
      end else begin
        r_move_left  <= r_move_left;
        r_move_right <= r_move_right;
      end
      r_move_down <= r_down_evt | (r_move_down & ~ack);
      r_rotate    <= r_rot_evt  | (r_rotate    & ~ack);
    end
  end

  assign move_left  = r_move_left;
  assign move_right = r_move_right;
  assign move_down  = r_move_down;
  assign rotate     = r_rotate;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Scoreboard bench for tetris_input_ctrl: stimulus queues the expected request
// rising edges with their cycle; a negedge monitor matches what the DUT shows.
module tb_tetris_input_ctrl;

  localparam logic [3:0] M_LEFT  = 4'b0001;
  localparam logic [3:0] M_RIGHT = 4'b0010;
  localparam logic [3:0] M_DOWN  = 4'b0100;
  localparam logic [3:0] M_ROT   = 4'b1000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] adc_value;
  logic        adc_valid;
  logic        btn_rotate_n;
  logic        btn_down_n;
  logic        ack;
  logic        move_left, move_right, move_down, rotate;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;
  exp_t exp_q[$];

  logic [3:0] mon_prev = 4'b0000;
  logic [3:0] mon_cur;
  logic [3:0] mon_rise;
  exp_t       mon_e;

  tetris_input_ctrl #(
    .ADC_W(12), .LEFT_THRESH(1000), .RIGHT_THRESH(3000), .HYST(100),
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .adc_value(adc_value), .adc_valid(adc_valid),
    .btn_rotate_n(btn_rotate_n), .btn_down_n(btn_down_n), .ack(ack),
    .move_left(move_left), .move_right(move_right), .move_down(move_down),
    .rotate(rotate)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every new request rising edge must match the head of the queue.
  always @(negedge clk) begin
    mon_cur  = {rotate, move_down, move_right, move_left};
    mon_rise = mon_cur & ~mon_prev;
    mon_prev = mon_cur;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL missed_event: required mask %b at cycle %0d, nothing seen by cycle %0d",
               exp_q[0].mask, exp_q[0].cyc, cyc);
      exp_q.delete(0);
    end
    if (mon_rise != 4'b0000) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_event: got mask %b at cycle %0d, required none", mon_rise, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.mask != mon_rise) begin
          tests_failed++;
          $display("FAIL event_match: got mask %b at cycle %0d, required mask %b at cycle %0d",
                   mon_rise, cyc, mon_e.mask, mon_e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int d, input logic [3:0] m);
    exp_q.push_back('{cyc + d, m});
  endtask

  task automatic check(input string name, input logic act, input logic req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    adc_value    = 12'd2048;
    adc_valid    = 1'b0;
    btn_rotate_n = 1'b1;
    btn_down_n   = 1'b1;
    ack          = 1'b0;
    step(3);
    check("reset_left",  move_left,  1'b0);
    check("reset_right", move_right, 1'b0);
    check("reset_down",  move_down,  1'b0);
    check("reset_rot",   rotate,     1'b0);
    reset_n = 1'b1;
    step(2);

    // 1: single left entry, held without ack, then cleared by ack
    adc_valid = 1'b1;
    adc_value = 12'd2048;
    step(2);
    adc_value = 12'd500;
    push_exp(2, M_LEFT);
    step(5);
    check("t1_left_held", move_left, 1'b1);
    check("t1_right_off", move_right, 1'b0);
    adc_value = 12'd2048;
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(1);
    check("t1_left_acked", move_left, 1'b0);
    step(3);

    // 2: held left with ack every cycle -> t0, +20, +28, +36
    ack = 1'b1;
    step(2);
    adc_value = 12'd500;
    push_exp(2,  M_LEFT);
    push_exp(22, M_LEFT);
    push_exp(30, M_LEFT);
    push_exp(38, M_LEFT);
    step(40);
    adc_value = 12'd2048;
    step(5);

    // 3: hysteresis on left exit, then right replaces a pending left
    ack = 1'b0;
    adc_value = 12'd500;
    push_exp(2, M_LEFT);
    step(3);
    adc_value = 12'd1050;
    step(2);
    adc_value = 12'd1100;
    step(2);
    adc_value = 12'd3500;
    push_exp(2, M_RIGHT);
    step(3);
    check("t3_left_cleared", move_left,  1'b0);
    check("t3_right_set",    move_right, 1'b1);
    adc_value = 12'd2048;
    step(1);
    ack = 1'b1;
    step(1);
    check("t3_right_acked", move_right, 1'b0);

    // Exact thresholds from CENTER must not enter a zone
    adc_value = 12'd1000;
    step(2);
    adc_value = 12'd3000;
    step(2);
    adc_value = 12'd2048;
    step(2);

    // 3b: right exit hysteresis and direct right -> left
    adc_value = 12'd3500;
    push_exp(2, M_RIGHT);
    step(3);
    adc_value = 12'd2901;
    step(2);
    adc_value = 12'd2900;
    step(2);
    adc_value = 12'd3500;
    push_exp(2, M_RIGHT);
    step(3);
    adc_value = 12'd500;
    push_exp(2, M_LEFT);
    step(3);
    adc_value = 12'd2048;
    step(5);

    // 4: rotate glitch, rotate long press, down with auto-repeat
    btn_rotate_n = 1'b0;
    step(2);
    btn_rotate_n = 1'b1;
    step(10);
    btn_rotate_n = 1'b0;
    push_exp(7, M_ROT);
    step(100);
    btn_rotate_n = 1'b1;
    step(10);
    btn_down_n = 1'b0;
    push_exp(7,  M_DOWN);
    push_exp(27, M_DOWN);
    push_exp(35, M_DOWN);
    push_exp(43, M_DOWN);
    push_exp(51, M_DOWN);
    push_exp(59, M_DOWN);
    step(58);
    btn_down_n = 1'b1;
    step(15);

    // 5: ack in the same cycle the rotate event lands
    ack = 1'b0;
    btn_rotate_n = 1'b0;
    push_exp(7, M_ROT);
    step(6);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t5_rot_event_wins", rotate, 1'b1);
    step(1);
    check("t5_rot_held", rotate, 1'b1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("t5_rot_acked", rotate, 1'b0);
    step(10);
    btn_rotate_n = 1'b1;
    step(10);

    // 6: reset mid-repeat, fresh entry and repeat after release
    adc_value = 12'd500;
    push_exp(2, M_LEFT);
    step(10);
    reset_n = 1'b0;
    #1;
    check("t6_rst_left",  move_left,  1'b0);
    check("t6_rst_right", move_right, 1'b0);
    check("t6_rst_down",  move_down,  1'b0);
    check("t6_rst_rot",   rotate,     1'b0);
    step(2);
    reset_n = 1'b1;
    push_exp(2, M_LEFT);
    step(3);
    ack = 1'b1;
    push_exp(19, M_LEFT);
    push_exp(27, M_LEFT);
    step(30);
    adc_value = 12'd2048;
    step(20);

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drained: got %0d pending events, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
